mdu_multicycle: RTL
===================

Name: mdu_multicycle

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Next-generation arithmetic block for the pipelined MIPS core; sits beside the ALU in the execute stage.
- Executes mult/multu/div/divu over configurable latencies, and mthi/mtlo in one cycle.
- Exposes Busy/Done so the core's stall logic can hold mfhi/mflo and further MDU instructions.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, >= 8)
MULT_CYCLES, 5, busy cycles for mult/multu (>= 1)
DIV_CYCLES, 10, busy cycles for div/divu (>= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
Start  input  1  operation request, sampled on clk edge
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
A  input  WIDTH  rs operand
B  input  WIDTH  rt operand
Flush  input  1  abort any in-flight operation
Busy  output  1  registered; high while a mult/div is in flight
Done  output  1  registered; one-cycle pulse when HI/LO commit from mult/div
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset, synchronous and active-high, has priority over everything:
  - HI=0, LO=0, Busy=0, Done=0, counter=0, state=IDLE.
  - Reset mid-operation discards the operation; no commit.
- States: IDLE, RUN.
- IDLE with Start=1:
  - Op 1-4: latch A, B and op; load counter = MULT_CYCLES or DIV_CYCLES; go to RUN; Busy=1 from the next cycle.
  - Op 5 (mthi): HI<=A at this edge. No Busy, no Done.
  - Op 6 (mtlo): LO<=A at this edge. No Busy, no Done.
  - Op 0 or 7: no-op.
- IDLE with Start=0: hold.
- RUN:
  - Decrement counter each edge.
  - On the edge where counter==1: commit HI/LO, Busy<=0, Done<=1, go to IDLE.
  - Start at issue edge t → Busy high cycles t+1..t+N → new HI/LO and Done=1 visible in cycle t+N+1.
  - Start during RUN (any op, including mthi/mtlo) is ignored; the core must stall on Busy.
- Flush:
  - In RUN: return to IDLE at that edge; Busy<=0; no commit; HI/LO keep old values; Done=0.
  - Flush with Start in IDLE: Flush wins; the op is dropped.
  - Flush in the same cycle as the commit edge: Flush wins; no commit.
- Done: deasserts after one cycle unless another commit occurs (impossible back-to-back, since N>=1 plus one issue edge).
- Arithmetic uses the latched operands; the result is computed combinationally and registered at commit (the internal implementation may be iterative if the latency fits N).
  - mult: signed 2*WIDTH product; HI=upper WIDTH bits, LO=lower WIDTH bits.
  - multu: unsigned product, same split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Divide by zero (div/divu): LO=all ones, HI=A.
  - Signed overflow (div with A=most-negative value, B=-1): LO=A, HI=0.
- A/B changes after the issue edge must not affect the result.

Test Plan:
- Reset then idle → HI=0, LO=0, Busy=0, Done=0; assert reset during RUN of mult → next cycle all outputs zero, no Done pulse.
- mult A=0xFFFFFFFE (-2), B=3, default params → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done=1 for one cycle; multu same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 → LO=3, HI=1.
- div by zero A=0x12345678, B=0 → LO=0xFFFFFFFF, HI=0x12345678; div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0xAAAA5555 → HI updates next cycle, Busy and Done stay 0; mtlo presented while Busy → ignored, LO unchanged.
- Flush after 3 busy cycles of mult with HI/LO preloaded 0x11/0x22 → Busy falls next cycle, no Done, HI=0x11, LO=0x22; Flush on the commit edge → same result.

Source files
------------

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// mult/div results are computed from latched operands and committed after a fixed latency.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  req_t             req_q, req_d;
  op_e              op_in;

  assign op_in = op_e'(MDUOp);

  // ---------------------------------------------------------------- arithmetic
  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic               signed_div, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0]   dvd, dvs, dvs_safe, uq, ur;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
  assign prod_u = {{WIDTH{1'b0}}, req_q.a} * {{WIDTH{1'b0}}, req_q.b};
  assign prod_s = {{WIDTH{req_q.a[WIDTH-1]}}, req_q.a} * {{WIDTH{req_q.b[WIDTH-1]}}, req_q.b};

  // Signed division runs on magnitudes; signs are restored afterwards.
  assign signed_div = (req_q.op == OP_DIV);
  assign a_neg      = signed_div & req_q.a[WIDTH-1];
  assign b_neg      = signed_div & req_q.b[WIDTH-1];
  assign dvd        = a_neg ? -req_q.a : req_q.a;
  assign dvs        = b_neg ? -req_q.b : req_q.b;
  assign div_zero   = (req_q.b == '0);
  assign div_ovf    = signed_div && (req_q.a == MOST_NEG) && (req_q.b == '1);
  assign dvs_safe   = div_zero ? WIDTH'(1) : dvs;
  assign uq         = dvd / dvs_safe;
  assign ur         = dvd % dvs_safe;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (req_q.op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (div_zero) begin
          res_lo = '1;
          res_hi = req_q.a;
        end else if (div_ovf) begin
          res_lo = req_q.a;
          res_hi = '0;
        end else begin
          res_lo = (a_neg ^ b_neg) ? -uq : uq;
          res_hi = a_neg ? -ur : ur;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        // Flush drops any op presented alongside it.
        if (Start && !Flush) begin
          case (op_in)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              req_d   = '{op: op_in, a: A, b: B};
              cnt_d   = (op_in == OP_MULT || op_in == OP_MULTU) ? MULT_N : DIV_N;
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Start is ignored here; the core stalls on Busy.
        if (Flush) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      req_q   <= req_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
